ld_result_reader: RTL and testbench

Read-side companion to the LD_Project core. It snapshots the core's four 5-bit result buses (fgt, frt, fgc, frc) and the two flag bits (fgp, frp) on a capture strobe. It then streams them out as a 5-beat frame over a valid/ready handshake, with per-word even parity. It sits between the LD_Project outputs and any downstream consumer, such as a UART/LED scanner or a bench monitor.

---
 rtl/ld_pkg.sv | 11 +
 rtl/ld_beat_mux.sv | 24 ++
 rtl/ld_result_reader.sv | 91 +++++++++
 tb/tb_ld_result_reader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ld_pkg.sv
// ld_pkg: shared state, beat index and width constants for ld_result_reader
package ld_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [2:0] IDX_FGT = 3'd0;
  localparam logic [2:0] IDX_FRT = 3'd1;
  localparam logic [2:0] IDX_FGC = 3'd2;
  localparam logic [2:0] IDX_FRC = 3'd3;
  localparam logic [2:0] IDX_FLG = 3'd4;
  localparam int NUM_BEATS = 5;
  localparam int LD_DATA_W = 5;
endpackage

// File: rtl/ld_beat_mux.sv
// ld_beat_mux: selects the snapshot word for the current beat and its even parity
module ld_beat_mux
  import ld_pkg::*;
#(
  parameter int DATA_W = LD_DATA_W
) (
  input  logic [2:0]        idx,
  input  logic [DATA_W-1:0] fgt,
  input  logic [DATA_W-1:0] frt,
  input  logic [DATA_W-1:0] fgc,
  input  logic [DATA_W-1:0] frc,
  input  logic              fgp,
  input  logic              frp,
  output logic [DATA_W-1:0] data,
  output logic              par
);
  always_comb begin
    data = idx == IDX_FGT ? fgt :
           idx == IDX_FRT ? frt :
           idx == IDX_FGC ? fgc :
           idx == IDX_FRC ? frc : {{(DATA_W-2){1'b0}}, frp, fgp};
    par = ^data;
  end
endmodule

// File: rtl/ld_result_reader.sv
// ld_result_reader: snapshots core results and streams them as a 5-beat valid/ready frame
// LD_READER_FRMCNT_EN enables the completed-frame counter on frame_cnt
module ld_result_reader
  import ld_pkg::*;
#(
  parameter int DATA_W = LD_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] fgt,
  input  logic [DATA_W-1:0] frt,
  input  logic [DATA_W-1:0] fgc,
  input  logic [DATA_W-1:0] frc,
  input  logic              fgp,
  input  logic              frp,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic              out_par,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic [CNT_W-1:0]  frame_cnt
);
  state_t state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [DATA_W-1:0] s_fgt, s_frt, s_fgc, s_frc;
  logic s_fgp, s_frp;
  logic load, xfer, done, set_ovr;
  assign out_valid = state == SEND;
  assign busy      = out_valid;
  assign out_idx   = idx;
  assign out_last  = idx == IDX_FLG;
  assign xfer      = out_valid & out_ready;
  assign done      = xfer & (idx == 3'(NUM_BEATS - 1));
  assign set_ovr   = busy & cap & ~done;
  // a capture on the final transfer edge reloads without a bubble
  always_comb begin
    load     = state == IDLE ? cap : done & cap;
    state_nx = state == IDLE ? (cap ? SEND : IDLE) : (done & ~cap ? IDLE : SEND);
    idx_nx   = (load | done) ? 3'd0 : xfer ? idx + 3'd1 : idx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
      s_fgt   <= '0;
      s_frt   <= '0;
      s_fgc   <= '0;
      s_frc   <= '0;
      s_fgp   <= 1'b0;
      s_frp   <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      overrun <= set_ovr | (overrun & ~clr_ovr);
      if (load) begin
        s_fgt <= fgt;
        s_frt <= frt;
        s_fgc <= fgc;
        s_frc <= frc;
        s_fgp <= fgp;
        s_frp <= frp;
      end
    end
  end
`ifdef LD_READER_FRMCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt <= '0;
    else if (done) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  assign frame_cnt = '0;
`endif
  ld_beat_mux #(.DATA_W(DATA_W)) u_mux (
    .idx (idx),
    .fgt (s_fgt),
    .frt (s_frt),
    .fgc (s_fgc),
    .frc (s_frc),
    .fgp (s_fgp),
    .frp (s_frp),
    .data(out_data),
    .par (out_par)
  );
endmodule

// File: tb/tb_ld_result_reader.sv
// tb_ld_result_reader: directed checks of capture, framing, backpressure, overrun and reset
module tb_ld_result_reader;
  logic clk = 0, rst_n, cap, out_ready, clr_ovr, fgp, frp;
  logic [4:0] fgt, frt, fgc, frc, out_data;
  logic out_valid, out_par, out_last, busy, overrun;
  logic [2:0] out_idx;
  logic [7:0] frame_cnt;
  int tests = 0, fails = 0;
  logic [4:0] exp_d [5];
  logic exp_p [5];

  ld_result_reader dut (
    .clk(clk), .rst_n(rst_n), .cap(cap), .fgt(fgt), .frt(frt), .fgc(fgc), .frc(frc),
    .fgp(fgp), .frp(frp), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_par(out_par), .out_last(out_last), .busy(busy),
    .overrun(overrun), .clr_ovr(clr_ovr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic words(input logic [4:0] w, input logic gp, input logic rp);
    fgt = w; frt = w; fgc = w; frc = w; fgp = gp; frp = rp;
  endtask

  initial begin
    rst_n = 0; cap = 0; out_ready = 0; clr_ovr = 0;
    words(5'h00, 0, 0);
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_par", out_par, 0);
    chk("rst_last", out_last, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst_n = 1;
    tick;
    // basic frame
    words(5'h1f, 1, 0);
    out_ready = 1; cap = 1;
    chk("pre_cap_valid", out_valid, 0);
    tick;
    cap = 0;
    exp_d = '{5'h1f, 5'h1f, 5'h1f, 5'h1f, 5'h01};
    exp_p = '{1, 1, 1, 1, 1};
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("basic_valid%0d", b), out_valid, 1);
      chk($sformatf("basic_idx%0d", b), out_idx, b);
      chk($sformatf("basic_data%0d", b), out_data, exp_d[b]);
      chk($sformatf("basic_par%0d", b), out_par, exp_p[b]);
      chk($sformatf("basic_last%0d", b), out_last, b == 4);
      tick;
    end
    chk("basic_end_valid", out_valid, 0);
    chk("basic_end_busy", busy, 0);
    // backpressure at idx2 with inputs changing during the stall
    words(5'h15, 1, 1);
    cap = 1; tick; cap = 0;
    tick; tick;
    out_ready = 0;
    words(5'h00, 0, 0);
    for (int s = 0; s < 3; s++) begin
      chk("bp_data", out_data, 5'h15);
      chk("bp_idx", out_idx, 2);
      chk("bp_par", out_par, 1);
      chk("bp_valid", out_valid, 1);
      tick;
    end
    out_ready = 1;
    chk("bp_hold_after", out_idx, 2);
    tick;
    chk("bp_idx3_data", out_data, 5'h15);
    tick;
    chk("bp_flag_data", out_data, 5'h03);
    chk("bp_flag_par", out_par, 0);
    chk("bp_flag_last", out_last, 1);
    tick;
    chk("bp_end_valid", out_valid, 0);
    // overrun: capture during idx1 is ignored and flagged
    words(5'h0a, 0, 1);
    cap = 1; tick; cap = 0;
    tick;
    chk("ovr_idx1", out_idx, 1);
    words(5'h00, 0, 0);
    cap = 1; tick; cap = 0;
    chk("ovr_set", overrun, 1);
    chk("ovr_old_data2", out_data, 5'h0a);
    tick;
    chk("ovr_old_data3", out_data, 5'h0a);
    tick;
    chk("ovr_old_flag", out_data, 5'h02);
    chk("ovr_old_par", out_par, 1);
    tick;
    chk("ovr_idle", out_valid, 0);
    chk("ovr_sticky", overrun, 1);
    clr_ovr = 1; tick; clr_ovr = 0;
    chk("ovr_clr", overrun, 0);
    cap = 1; tick; cap = 0;
    cap = 1; clr_ovr = 1; tick; cap = 0; clr_ovr = 0;
    chk("ovr_set_wins", overrun, 1);
    tick; tick; tick; tick;
    chk("ovr2_idle", out_valid, 0);
    clr_ovr = 1; tick; clr_ovr = 0;
    chk("ovr2_clr", overrun, 0);
    // back-to-back: capture on the final transfer edge
    words(5'h1c, 0, 0);
    cap = 1; tick; cap = 0;
    tick; tick; tick; tick;
    chk("b2b_idx4", out_idx, 4);
    words(5'h00, 0, 0);
    cap = 1; tick; cap = 0;
    chk("b2b_idx", out_idx, 0);
    chk("b2b_data", out_data, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_ovr", overrun, 0);
    tick; tick; tick; tick; tick;
    chk("b2b_end", out_valid, 0);
    // reset mid-frame
    words(5'h07, 1, 1);
    cap = 1; tick; cap = 0;
    tick; tick; tick;
    chk("mid_idx3", out_idx, 3);
    rst_n = 0; tick;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    rst_n = 1;
    for (int s = 0; s < 3; s++) begin
      tick;
      chk("post_rst_quiet", out_valid, 0);
    end
    // frame counter wrap after 257 frames
    words(5'h09, 0, 0);
    for (int f = 0; f < 257; f++) begin
      cap = 1; tick; cap = 0;
      tick; tick; tick; tick; tick;
    end
    chk("cnt_idle", out_valid, 0);
`ifdef LD_READER_FRMCNT_EN
    chk("cnt_wrap", frame_cnt, 1);
`else
    chk("cnt_tied", frame_cnt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
